alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Two-requester issue controller that shares one combinational 32-bit ALU between requester 0 (execute pipe) and requester 1 (address/auxiliary unit).
- Arbitrates round-robin and registers operands onto the ALU inputs.
- Stretches multi-cycle ops (ALU mcp flag), captures the result and holds it until the requester consumes it.
- Owns a per-requester carry/overflow flag context that feeds the ALU's cin/vin.

Parameters:
- DW, 32, datapath width; the ALU is 32-bit, and only 32 is supported.
- OPW, 6, opcode width.
- MCP_CYCLES, 2, extra cycles held when the ALU flags a multi-cycle op (legal range 1..7).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_b  in  1  synchronous active-low reset.
- reqN_valid  in  1  (N=0,1) request valid.
- reqN_ready  out  1  accept strobe; an op transfers when reqN_valid & reqN_ready.
- reqN_opcode  in  OPW  ALU opcode.
- reqN_a, reqN_b  in  DW  operands.
- reqN_setflags  in  1  update this requester's C/V flags on completion.
- rspN_valid  out  1  result valid.
- rspN_ready  in  1  requester consumes the result.
- rspN_data  out  DW  result.
- rspN_c, rspN_v  out  1  ALU cout/vout for this op, reported regardless of setflags.
- flagN_c, flagN_v  out  1  current flag context.
- flag_wr_en  in  1  direct flag write, used for context restore.
- flag_wr_sel  in  1  requester whose flags are written.
- flag_wr_c, flag_wr_v  in  1  values written.
- alu_a, alu_b  out  DW  registered operands to the ALU.
- alu_opcode  out  OPW  registered opcode.
- alu_cin, alu_vin  out  1  flags of the granted requester.
- alu_dout  in  DW  ALU result.
- alu_cout, alu_vout, alu_mcp  in  1  ALU outputs.

Behaviour:
- Reset (reset_b=0 at a clock edge):
  - state=IDLE; RR pointer=0; all flags=0.
  - alu_a/alu_b=0, alu_opcode=0; reqN_ready=0; rspN_valid=0; rspN_data=0, rspN_c=0, rspN_v=0.
  - Reset mid-operation discards the in-flight op; no response is ever produced for it.
- States are IDLE, EXEC, STRETCH and RESP.
- IDLE:
  - reqN_ready is combinational: asserted only in IDLE, for the granted requester only.
  - Grant rule: if exactly one valid, grant it; if both valid, grant the RR pointer's requester.
  - On accept: latch opcode/a/b/setflags/grant into operand registers, then go to EXEC.
  - No ready is asserted when no requester is valid.
- EXEC:
  - The ALU settles on the registered inputs.
  - alu_cin/alu_vin = flags of the granted requester.
  - If alu_mcp=0: capture alu_dout/cout/vout, then go to RESP.
  - If alu_mcp=1: load the counter with MCP_CYCLES, then go to STRETCH.
- STRETCH:
  - Decrement the counter each cycle.
  - When counter==1: capture, then go to RESP.
  - The operand registers stay stable throughout.
- Capture:
  - If setflags=1, write cout/vout into the granted requester's flags at the capture edge.
  - If flag_wr_en targets the same requester in the same cycle, flag_wr wins.
- RESP:
  - rspN_valid=1 for the granted requester only; data and flags are held stable until rspN_ready.
  - On the handshake: rspN_valid drops next cycle; the RR pointer moves to the other requester; go to IDLE.
  - rspN_ready while rspN_valid=0 is ignored.
- Latency, with the accept edge at T:
  - Plain op: rsp_valid high from T+2.
  - mcp op: rsp_valid high from T+2+MCP_CYCLES.
  - Minimum issue interval is 3 cycles (accept, EXEC, RESP handshake).
- Flag write: flag_wr_en updates the selected flag pair in any state. A write to the granted requester during EXEC/STRETCH takes effect at the next edge; alu_cin/alu_vin follow it combinationally.
- A requester holding valid without acceptance must keep its payload stable; the controller never drops a pending valid.

Decomposition:
- Shared header alu_ctrl.vh: state encodings (IDLE/EXEC/STRETCH/RESP) and the MCP counter width.
- Opcode constants come from the existing CPU opcode header.
- One sub-module: rr_arb2.
  - 2-way round-robin arbiter.
  - Inputs: req[1:0], pointer, enable.
  - Output: one-hot gnt.
  - Pointer update is owned by the parent.

Test Plan:
- Req0 ADD a=0x7FFFFFFF b=0x00000001 setflags=1 -> rsp0_data=0x80000000, rsp0_v=1, rsp0_c=0 at T+2; flag0_v=1; flag1 unchanged.
- Both valid in the same cycle, repeated 4 ops each -> grants alternate 0,1,0,1…; each requester gets exactly 4 responses in issue order.
- ALU model asserts alu_mcp for MUL with a=3 b=5, MCP_CYCLES=2 -> rsp valid at T+4, data=0x0000000F; alu_a/alu_b stable T+1..T+3.
- Hold rsp1_ready=0 for 10 cycles after the result -> rsp1_valid/data held; req0_ready stays 0 throughout; req0 accepted the cycle after the rsp1 handshake.
- Assert reset_b=0 during STRETCH -> next cycle state IDLE, all rsp_valid=0, flags=0; no stale response appears after release.
- flag_wr_en sel=0 c=1 v=0 in the capture cycle of a setflags SUB that produces c=0, v=1 -> flag0_c=1, flag0_v=0.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the two-requester ALU issue controller:
//   - controller state encoding (IDLE/EXEC/STRETCH/RESP)
//   - width of the multi-cycle stretch counter (covers MCP_CYCLES 1..7)
//   - CPU opcode constants used by requesters and the ALU
// -----------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    STRETCH = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam int MCP_CNT_W = 3;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_ADC = 6'h02;
  localparam logic [5:0] OP_AND = 6'h04;
  localparam logic [5:0] OP_XOR = 6'h05;
  localparam logic [5:0] OP_MUL = 6'h08;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The pointer names the
// requester that wins a tie; the parent owns and advances the pointer.
// Ports:
//   req[1:0]  request vector
//   ptr       tie-break winner (0 or 1)
//   en        arbitration enable; no grant when low
//   gnt[1:0]  one-hot grant (all zero when disabled or no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: default first so every path assigns gnt and no latch is inferred.
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Shares one combinational ALU between requester 0 (execute pipe) and
// requester 1 (address/aux unit). Round-robin arbitration in IDLE, registered
// ALU operands, optional multi-cycle stretch, result held until consumed, and a
// per-requester C/V flag context feeding alu_cin/alu_vin.
// Ports:
//   clk, reset_b                  clock, synchronous active-low reset
//   reqN_valid/ready/opcode/a/b/setflags   request channel N (N=0,1)
//   rspN_valid/ready/data/c/v     response channel N
//   flagN_c/flagN_v               current flag context of requester N
//   flag_wr_en/sel/c/v            direct flag write (context restore)
//   alu_a/alu_b/alu_opcode        registered ALU operands
//   alu_cin/alu_vin               flags of the granted requester
//   alu_dout/cout/vout/mcp        ALU results and multi-cycle flag
// -----------------------------------------------------------------------------
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DW         = 32,
  parameter int OPW        = 6,
  parameter int MCP_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_opcode,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req0_setflags,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_opcode,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic           req1_setflags,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_data,
  output logic           rsp0_c,
  output logic           rsp0_v,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_data,
  output logic           rsp1_c,
  output logic           rsp1_v,
  output logic           flag0_c,
  output logic           flag0_v,
  output logic           flag1_c,
  output logic           flag1_v,
  input  logic           flag_wr_en,
  input  logic           flag_wr_sel,
  input  logic           flag_wr_c,
  input  logic           flag_wr_v,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_opcode,
  output logic           alu_cin,
  output logic           alu_vin,
  input  logic [DW-1:0]  alu_dout,
  input  logic           alu_cout,
  input  logic           alu_vout,
  input  logic           alu_mcp
);

  localparam logic [MCP_CNT_W-1:0] MCP_LOAD = MCP_CNT_W'(MCP_CYCLES);
  localparam logic [MCP_CNT_W-1:0] CNT_LAST = MCP_CNT_W'(1);

  state_e               state;
  logic [MCP_CNT_W-1:0] cnt;
  logic                 rr_ptr;
  logic                 gnt_idx;      // requester owning the in-flight op
  logic                 op_setflags;
  logic [1:0]           flag_c;
  logic [1:0]           flag_v;
  logic [1:0]           rsp_vld;      // one-hot per requester
  logic [DW-1:0]        rsp_data;
  logic                 rsp_c;
  logic                 rsp_v;

  logic [1:0] gnt;
  logic       capture;
  logic       rsp_fire;

  rr_arb2 u_arb (
    .req (|{req1_valid, req0_valid} ? {req1_valid, req0_valid} : 2'b00),
    .ptr (rr_ptr),
    .en  (state == IDLE),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // ALU result is sampled at the last cycle of the op: EXEC for single-cycle
  // ops, the final STRETCH cycle for multi-cycle ones.
  assign capture  = ((state == EXEC) && !alu_mcp) ||
                    ((state == STRETCH) && (cnt == CNT_LAST));
  assign rsp_fire = |(rsp_vld & {rsp1_ready, rsp0_ready});

  // Flags feed the ALU straight from the context registers, so a flag write
  // during EXEC/STRETCH is seen by the ALU right after the write edge.
  assign alu_cin = flag_c[gnt_idx];
  assign alu_vin = flag_v[gnt_idx];

  assign flag0_c = flag_c[0];
  assign flag0_v = flag_v[0];
  assign flag1_c = flag_c[1];
  assign flag1_v = flag_v[1];

  assign rsp0_valid = rsp_vld[0];
  assign rsp1_valid = rsp_vld[1];
  assign rsp0_data  = rsp_data;
  assign rsp1_data  = rsp_data;
  assign rsp0_c     = rsp_c;
  assign rsp1_c     = rsp_c;
  assign rsp0_v     = rsp_v;
  assign rsp1_v     = rsp_v;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= 1'b0;
      gnt_idx     <= 1'b0;
      op_setflags <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      flag_c      <= '0;
      flag_v      <= '0;
      rsp_vld     <= '0;
      rsp_data    <= '0;
      rsp_c       <= 1'b0;
      rsp_v       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            alu_a       <= gnt[1] ? req1_a : req0_a;
            alu_b       <= gnt[1] ? req1_b : req0_b;
            alu_opcode  <= gnt[1] ? req1_opcode : req0_opcode;
            op_setflags <= gnt[1] ? req1_setflags : req0_setflags;
            gnt_idx     <= gnt[1];
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (alu_mcp) begin
            cnt   <= MCP_LOAD;
            state <= STRETCH;
          end else begin
            state <= RESP;
          end
        end
        STRETCH: begin
          if (cnt == CNT_LAST) state <= RESP;
          else                 cnt   <= cnt - 1'b1;
        end
        RESP: begin
          if (rsp_fire) begin
            rsp_vld <= '0;
            rr_ptr  <= ~gnt_idx;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (capture) begin
        rsp_data <= alu_dout;
        rsp_c    <= alu_cout;
        rsp_v    <= alu_vout;
        rsp_vld  <= gnt_idx ? 2'b10 : 2'b01;
        if (op_setflags) begin
          flag_c[gnt_idx] <= alu_cout;
          flag_v[gnt_idx] <= alu_vout;
        end
      end

      // Placed after the capture update so a direct write to the same
      // requester in the capture cycle overrides the ALU flags.
      if (flag_wr_en) begin
        flag_c[flag_wr_sel] <= flag_wr_c;
        flag_v[flag_wr_sel] <= flag_wr_v;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int OPW = 6;
  localparam int MCP = 2;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // requester-side signals
  logic           req_valid [2] = '{1'b0, 1'b0};
  logic           req_ready [2];
  logic [OPW-1:0] req_op    [2] = '{6'h0, 6'h0};
  logic [DW-1:0]  req_a     [2] = '{32'h0, 32'h0};
  logic [DW-1:0]  req_b     [2] = '{32'h0, 32'h0};
  logic           req_sf    [2] = '{1'b0, 1'b0};
  logic           rsp_valid [2];
  logic           rsp_ready [2] = '{1'b0, 1'b0};
  logic [DW-1:0]  rsp_data  [2];
  logic           rsp_c     [2];
  logic           rsp_v     [2];
  logic           flag_c    [2];
  logic           flag_v    [2];
  logic flag_wr_en = 1'b0, flag_wr_sel = 1'b0, flag_wr_c = 1'b0, flag_wr_v = 1'b0;

  logic [DW-1:0]  alu_a, alu_b, alu_dout;
  logic [OPW-1:0] alu_opcode;
  logic alu_cin, alu_vin, alu_cout, alu_vout, alu_mcp;

  // background driver controls
  bit auto_rsp = 1'b0, rand_flag = 1'b0;
  bit man_rsp [2] = '{1'b0, 1'b0};
  bit man_fw_en = 1'b0, man_fw_sel = 1'b0, man_fw_c = 1'b0, man_fw_v = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  alu_issue_ctrl #(.DW(DW), .OPW(OPW), .MCP_CYCLES(MCP)) dut (
    .clk(clk), .reset_b(reset_b),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_opcode(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_setflags(req_sf[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_opcode(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_setflags(req_sf[1]),
    .rsp0_valid(rsp_valid[0]), .rsp0_ready(rsp_ready[0]), .rsp0_data(rsp_data[0]),
    .rsp0_c(rsp_c[0]), .rsp0_v(rsp_v[0]),
    .rsp1_valid(rsp_valid[1]), .rsp1_ready(rsp_ready[1]), .rsp1_data(rsp_data[1]),
    .rsp1_c(rsp_c[1]), .rsp1_v(rsp_v[1]),
    .flag0_c(flag_c[0]), .flag0_v(flag_v[0]), .flag1_c(flag_c[1]), .flag1_v(flag_v[1]),
    .flag_wr_en(flag_wr_en), .flag_wr_sel(flag_wr_sel), .flag_wr_c(flag_wr_c), .flag_wr_v(flag_wr_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin), .alu_vin(alu_vin),
    .alu_dout(alu_dout), .alu_cout(alu_cout), .alu_vout(alu_vout), .alu_mcp(alu_mcp)
  );

  // Reference ALU behaviour: returns {mcp, cout, vout, dout}.
  function automatic logic [34:0] alu_ref(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin, input logic vin);
    logic [32:0] s;
    logic [31:0] d;
    logic c, v, m;
    m = 1'b0; c = cin; v = vin; s = '0; d = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; d = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (d[31] != a[31]);
      end
      OP_ADC: begin
        s = {1'b0, a} + {1'b0, b} + {32'b0, cin}; d = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (d[31] != a[31]);
      end
      OP_SUB: begin
        d = a - b; c = (a < b);
        v = (a[31] != b[31]) && (d[31] != a[31]);
      end
      OP_AND: d = a & b;
      OP_XOR: d = a ^ b;
      OP_MUL: begin d = a * b; c = 1'b0; v = 1'b0; m = 1'b1; end
      default: d = '0;
    endcase
    return {m, c, v, d};
  endfunction

  logic [34:0] alu_res;
  always_comb alu_res = alu_ref(alu_opcode, alu_a, alu_b, alu_cin, alu_vin);
  assign {alu_mcp, alu_cout, alu_vout, alu_dout} = alu_res;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model. At most one op is in flight; its
  // response window is fixed by the accept cycle and whether it is a MUL.
  // Stepped once per cycle at the falling edge: compare, then apply the
  // events of the coming rising edge.
  // ---------------------------------------------------------------------------
  bit          m_on = 1'b0, m_busy = 1'b0, m_have = 1'b0, m_owner = 1'b0, m_ptr = 1'b0, m_sf = 1'b0;
  int          m_cap_at = 0;
  logic [5:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_rd = '0;
  bit          m_rc = 1'b0, m_rv = 1'b0;
  bit          m_fc [2] = '{1'b0, 1'b0};
  bit          m_fv [2] = '{1'b0, 1'b0};
  int          n_rsp [2] = '{0, 0};
  int          grant_log [$];

  always @(negedge clk) begin : model
    logic [1:0]  vld, exp_rdy, exp_rv;
    logic [34:0] r;
    bit          was_busy, was_have;
    vld = {req_valid[1], req_valid[0]};
    exp_rdy = 2'b00;
    if (!m_busy) begin
      if (vld == 2'b01)      exp_rdy = 2'b01;
      else if (vld == 2'b10) exp_rdy = 2'b10;
      else if (vld == 2'b11) exp_rdy = m_ptr ? 2'b10 : 2'b01;
    end
    if (m_on) begin
      check("req_ready", {req_ready[1], req_ready[0]}, exp_rdy);
      exp_rv = (m_busy && m_have) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("rsp_valid", {rsp_valid[1], rsp_valid[0]}, exp_rv);
      if (m_busy && m_have) begin
        check("rsp_data", rsp_data[m_owner], m_rd);
        check("rsp_cv", {rsp_c[m_owner], rsp_v[m_owner]}, {m_rc, m_rv});
      end
      check("flags", {flag_c[1], flag_v[1], flag_c[0], flag_v[0]},
            {m_fc[1], m_fv[1], m_fc[0], m_fv[0]});
      if (m_busy && !m_have) begin
        check("alu_operands", {alu_opcode, alu_a, alu_b}, {m_op, m_a, m_b});
        check("alu_cin_vin", {alu_cin, alu_vin}, {m_fc[m_owner], m_fv[m_owner]});
      end
    end
    if (!reset_b) begin
      m_on = 1'b1; m_busy = 1'b0; m_have = 1'b0; m_ptr = 1'b0;
      m_fc[0] = 1'b0; m_fc[1] = 1'b0; m_fv[0] = 1'b0; m_fv[1] = 1'b0;
    end else if (m_on) begin
      was_busy = m_busy;
      was_have = m_have;
      if (was_busy && was_have && rsp_ready[m_owner]) begin
        m_busy = 1'b0; m_have = 1'b0; m_ptr = !m_owner;
        n_rsp[m_owner]++;
      end
      if (was_busy && !was_have && cyc == m_cap_at) begin
        r = alu_ref(m_op, m_a, m_b, m_fc[m_owner], m_fv[m_owner]);
        m_rd = r[31:0]; m_rv = r[32]; m_rc = r[33]; m_have = 1'b1;
        if (m_sf) begin m_fc[m_owner] = r[33]; m_fv[m_owner] = r[32]; end
      end
      if (flag_wr_en) begin
        m_fc[flag_wr_sel] = flag_wr_c;
        m_fv[flag_wr_sel] = flag_wr_v;
      end
      if (!was_busy && exp_rdy != 2'b00) begin
        m_owner = exp_rdy[1];
        m_busy = 1'b1; m_have = 1'b0;
        m_op = req_op[m_owner]; m_a = req_a[m_owner]; m_b = req_b[m_owner]; m_sf = req_sf[m_owner];
        m_cap_at = cyc + 1 + ((m_op == OP_MUL) ? MCP : 0);
        grant_log.push_back(int'(m_owner));
      end
    end
  end

  // Response-ready and flag-write driver (random or manual modes).
  initial forever begin
    @(posedge clk); #2;
    for (int n = 0; n < 2; n++)
      rsp_ready[n] = auto_rsp ? ($urandom_range(0, 2) != 0) : man_rsp[n];
    if (rand_flag) begin
      flag_wr_en  = ($urandom_range(0, 7) == 0);
      flag_wr_sel = 1'($urandom);
      flag_wr_c   = 1'($urandom);
      flag_wr_v   = 1'($urandom);
    end else begin
      flag_wr_en = man_fw_en; flag_wr_sel = man_fw_sel; flag_wr_c = man_fw_c; flag_wr_v = man_fw_v;
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 5))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_ADC;
      3: return OP_AND;
      4: return OP_XOR;
      default: return OP_MUL;
    endcase
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Holds valid and payload until accepted; returns the accept cycle.
  task automatic issue(input int n, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf, output int acc);
    acc = -1;
    req_op[n] = op; req_a[n] = a; req_b[n] = b; req_sf[n] = sf; req_valid[n] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (req_ready[n]) begin acc = cyc; break; end
    end
    if (acc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout req%0d: no ready within 400 cycles", n);
    end
    @(posedge clk); #1;
    req_valid[n] = 1'b0; req_a[n] = $urandom; req_b[n] = $urandom;
  endtask

  task automatic wait_rsp(input int n, output int when);
    when = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rsp_valid[n]) begin when = cyc; break; end
    end
    if (when < 0) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_timeout rsp%0d: no valid within 100 cycles", n);
    end
  endtask

  task automatic consume(input int n);
    @(posedge clk); #1; man_rsp[n] = 1'b1;
    @(posedge clk); #1; man_rsp[n] = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!m_busy) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL idle_timeout: controller still busy after 300 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_req(input int n, input int count);
    int acc;
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      issue(n, rand_op(), rand_val(), rand_val(), 1'($urandom), acc);
    end
  endtask

  initial begin : main
    int t_acc, t_rsp, g0, r0, r1;

    // reset
    reset_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;
    @(negedge clk);
    check("rst_ready", {req_ready[1], req_ready[0]}, 2'b00);
    check("rst_rsp_valid", {rsp_valid[1], rsp_valid[0]}, 2'b00);
    check("rst_rsp_data", {rsp_data[0], rsp_c[0], rsp_v[0]}, 34'h0);
    check("rst_alu_in", {alu_opcode, alu_a, alu_b}, 70'h0);
    check("rst_flags", {flag_c[1], flag_v[1], flag_c[0], flag_v[0]}, 4'b0000);
    @(posedge clk); #1;

    // ADD overflow with setflags
    issue(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, t_acc);
    wait_rsp(0, t_rsp);
    check("add_latency", t_rsp, t_acc + 2);
    check("add_data", rsp_data[0], 32'h8000_0000);
    check("add_cv", {rsp_c[0], rsp_v[0]}, 2'b01);
    check("add_flag0", {flag_c[0], flag_v[0]}, 2'b01);
    check("add_flag1", {flag_c[1], flag_v[1]}, 2'b00);
    consume(0);

    // SUB with a direct flag write landing on its capture edge
    issue(0, OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b1, t_acc);
    man_fw_en = 1'b1; man_fw_sel = 1'b0; man_fw_c = 1'b1; man_fw_v = 1'b0;
    @(posedge clk); #1;
    man_fw_en = 1'b0;
    wait_rsp(0, t_rsp);
    check("sub_data", rsp_data[0], 32'h7FFF_FFFF);
    check("sub_cv", {rsp_c[0], rsp_v[0]}, 2'b01);
    check("sub_flag0_wr_wins", {flag_c[0], flag_v[0]}, 2'b10);
    consume(0);

    // MUL multi-cycle op, then held response with req0 waiting
    issue(1, OP_MUL, 32'd3, 32'd5, 1'b0, t_acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mul_alu_a_stable", alu_a, 32'd3);
      check("mul_alu_b_stable", alu_b, 32'd5);
      @(posedge clk); #1;
    end
    wait_rsp(1, t_rsp);
    check("mul_latency", t_rsp, t_acc + 4);
    check("mul_data", rsp_data[1], 32'h0000_000F);
    @(posedge clk); #1;
    req_op[0] = OP_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2; req_sf[0] = 1'b0; req_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("hold_rsp1_valid", rsp_valid[1], 1'b1);
      check("hold_rsp1_data", rsp_data[1], 32'h0000_000F);
      check("hold_req0_ready", req_ready[0], 1'b0);
      @(posedge clk); #1;
    end
    man_rsp[1] = 1'b1;
    @(posedge clk); #1;
    man_rsp[1] = 1'b0;
    @(negedge clk);
    check("req0_ready_after_hs", req_ready[0], 1'b1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp(0, t_rsp);
    check("held_add_data", rsp_data[0], 32'd3);
    consume(0);

    // give requester 1 a non-zero flag context, then reset during STRETCH
    man_fw_en = 1'b1; man_fw_sel = 1'b1; man_fw_c = 1'b1; man_fw_v = 1'b1;
    @(posedge clk); #1;
    man_fw_en = 1'b0;
    issue(0, OP_MUL, 32'd7, 32'd9, 1'b1, t_acc);
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    @(negedge clk);
    check("stretch_rst_rsp_valid", {rsp_valid[1], rsp_valid[0]}, 2'b00);
    check("stretch_rst_flags", {flag_c[1], flag_v[1], flag_c[0], flag_v[0]}, 4'b0000);
    check("stretch_rst_alu_a", alu_a, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale_rsp", {rsp_valid[1], rsp_valid[0]}, 2'b00);
    end
    @(posedge clk); #1;

    // both requesters contending: grants alternate starting with 0
    auto_rsp = 1'b1;
    g0 = grant_log.size(); r0 = n_rsp[0]; r1 = n_rsp[1];
    fork
      begin
        int a0;
        for (int k = 0; k < 4; k++) issue(0, rand_op(), rand_val(), rand_val(), 1'($urandom), a0);
      end
      begin
        int a1;
        for (int k = 0; k < 4; k++) issue(1, rand_op(), rand_val(), rand_val(), 1'($urandom), a1);
      end
    join
    wait_idle();
    check("alt_grant_count", grant_log.size() - g0, 8);
    for (int k = 0; k < 8; k++)
      if (g0 + k < grant_log.size()) check($sformatf("alt_grant_%0d", k), grant_log[g0 + k], k % 2);
    check("alt_rsp0_count", n_rsp[0] - r0, 4);
    check("alt_rsp1_count", n_rsp[1] - r1, 4);

    // randomized traffic with random flag writes and response back-pressure
    rand_flag = 1'b1;
    fork
      rand_req(0, 60);
      rand_req(1, 60);
    join
    rand_flag = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
